if_id_fetch_buffer: RTL and testbench

//   Consumer end of the IF stage output. Queues {pc, instruction} pairs fetched by IF and

---
 rtl/if_id_fetch_buffer_pkg.sv | 23 ++
 rtl/if_id_fetch_buffer_storage.sv | 34 +++
 rtl/if_id_fetch_buffer.sv | 126 ++++++++++++
 tb/tb_if_id_fetch_buffer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared types and constants for the IF/ID fetch buffer.
//   WORD_WIDTH    : width of pc and instruction words
//   NOP_INSTR     : instruction presented to ID when no valid word is queued
//   fetch_entry_t : one queued {pc, instruction} pair
//   occ_state_t   : occupancy state decoded from the entry count
package if_id_fetch_buffer_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

endpackage

// File: rtl/if_id_fetch_buffer_storage.sv
// Register array holding the queued fetch entries.
// The array has no reset. Whether an entry is valid is tracked entirely by the
// pointers and the count in the parent block.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry to store
//   raddr : read slot (asynchronous read)
//   rdata : entry currently at raddr
module if_id_fetch_buffer_storage
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fetch_entry_t      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output fetch_entry_t      rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_buffer.sv
// Small FIFO between the IF and ID stages. It replaces the plain IF/ID register.
// It queues {pc, instruction} pairs from IF and hands them to ID with a
// valid/ready handshake. A taken branch flushes every queued word and the word
// arriving in the same cycle.
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   if_valid       : IF presents a fetched word
//   if_pc          : pc of the fetched word
//   if_instruction : fetched instruction
//   if_ready       : buffer can accept a word; IF freezes its PC when low
//   flush          : branch taken in EXE; drop everything
//   id_ready       : ID consumes the head this cycle
//   id_valid       : head entry is valid
//   id_pc          : head pc (0 when id_valid is low)
//   id_instruction : head instruction (NOP_INSTR when id_valid is low)
//   count          : number of occupied entries
module if_id_fetch_buffer
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = if_id_fetch_buffer_pkg::WORD_WIDTH,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [WORD_WIDTH-1:0] if_pc,
  input  logic [WORD_WIDTH-1:0] if_instruction,
  output logic                  if_ready,
  input  logic                  flush,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [WORD_WIDTH-1:0] id_pc,
  output logic [WORD_WIDTH-1:0] id_instruction,
  output logic [CNT_W-1:0]      count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0] count_q, count_next;
  occ_state_t       occ;
  logic             push, pop;
  fetch_entry_t     wr_entry, head;

  // Occupancy is decoded from the registered count only. This keeps if_ready
  // free of any combinational path from id_ready.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == DEPTH_C) begin
      occ = OCC_FULL;
    end
  end

  // If the buffer is full, a pop frees a slot only on the next cycle.
  // During a flush if_ready is forced high so that IF can load the branch
  // target. No push happens in that cycle because flush masks it.
  always_comb begin
    id_valid = (occ != OCC_EMPTY);
    if_ready = (occ != OCC_FULL) | flush;
    push     = if_valid & if_ready & ~flush;
    pop      = id_valid & id_ready & ~flush;
  end

  // Next-state logic. Flush has priority over both push and pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count_q;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      count_q <= count_next;
    end
  end

  assign wr_entry.pc    = if_pc;
  assign wr_entry.instr = if_instruction;

  if_id_fetch_buffer_storage #(
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // The head is read straight from storage. Stale slots are masked by id_valid.
  assign id_pc          = id_valid ? head.pc    : '0;
  assign id_instruction = id_valid ? head.instr : NOP_INSTR;
  assign count          = count_q;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [1:0]  count;

  int tests    = 0;
  int failures = 0;

  typedef struct packed {
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_ready;
    logic        exp_id_valid;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_instr;
    logic        exp_if_ready;
    logic [1:0]  exp_count;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  if_id_fetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instruction(if_instruction),
    .if_ready      (if_ready),
    .flush         (flush),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instruction(id_instruction),
    .count         (count)
  );

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                              input logic fl, input logic ir, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eins,
                              input logic erdy, input logic [1:0] ecnt);
    vec_t v;
    v.if_valid     = iv;
    v.if_pc        = pc;
    v.if_instr     = ins;
    v.flush        = fl;
    v.id_ready     = ir;
    v.exp_id_valid = ev;
    v.exp_id_pc    = epc;
    v.exp_id_instr = eins;
    v.exp_if_ready = erdy;
    v.exp_count    = ecnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] eins, input logic erdy, input logic [1:0] ecnt);
    checkOutput({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, ev});
    checkOutput({tag, " id_pc"}, id_pc, epc);
    checkOutput({tag, " id_instruction"}, id_instruction, eins);
    checkOutput({tag, " if_ready"}, {31'b0, if_ready}, {31'b0, erdy});
    checkOutput({tag, " count"}, {30'b0, count}, {30'b0, ecnt});
  endtask

  // Inputs are driven on the falling edge and outputs are checked 1ns later.
  // The next rising edge then commits the vector.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    if_valid       = v.if_valid;
    if_pc          = v.if_pc;
    if_instruction = v.if_instr;
    flush          = v.flush;
    id_ready       = v.id_ready;
    #1;
    checkAll($sformatf("vec%0d", idx), v.exp_id_valid, v.exp_id_pc, v.exp_id_instr,
             v.exp_if_ready, v.exp_count);
  endtask

  initial begin
    // Fill with id_ready low; a third word is offered while full.
    vecs[0]  = mk(1, 32'h4,   32'hE3A01001, 0, 0, 0, 32'h0,   32'h0,        1, 2'd0);
    vecs[1]  = mk(1, 32'h8,   32'hE2811002, 0, 0, 1, 32'h4,   32'hE3A01001, 1, 2'd1);
    vecs[2]  = mk(1, 32'hC,   32'h11111111, 0, 0, 1, 32'h4,   32'hE3A01001, 0, 2'd2);
    // Drain from full.
    vecs[3]  = mk(0, 32'h0,   32'h0,        0, 1, 1, 32'h4,   32'hE3A01001, 0, 2'd2);
    vecs[4]  = mk(0, 32'h0,   32'h0,        0, 1, 1, 32'h8,   32'hE2811002, 1, 2'd1);
    vecs[5]  = mk(0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 2'd0);
    // Streaming push+pop with count held at 1 while the pointers wrap.
    vecs[6]  = mk(1, 32'h4,   32'hA0,       0, 1, 0, 32'h0,   32'h0,        1, 2'd0);
    vecs[7]  = mk(1, 32'h8,   32'hA1,       0, 1, 1, 32'h4,   32'hA0,       1, 2'd1);
    vecs[8]  = mk(1, 32'hC,   32'hA2,       0, 1, 1, 32'h8,   32'hA1,       1, 2'd1);
    vecs[9]  = mk(1, 32'h10,  32'hA3,       0, 1, 1, 32'hC,   32'hA2,       1, 2'd1);
    vecs[10] = mk(1, 32'h14,  32'hA4,       0, 1, 1, 32'h10,  32'hA3,       1, 2'd1);
    vecs[11] = mk(0, 32'h0,   32'h0,        0, 1, 1, 32'h14,  32'hA4,       1, 2'd1);
    vecs[12] = mk(0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 2'd0);
    // Flush while full with an incoming word at pc=C.
    vecs[13] = mk(1, 32'h100, 32'hB0,       0, 0, 0, 32'h0,   32'h0,        1, 2'd0);
    vecs[14] = mk(1, 32'h104, 32'hB1,       0, 0, 1, 32'h100, 32'hB0,       1, 2'd1);
    vecs[15] = mk(1, 32'hC,   32'hCC,       1, 0, 1, 32'h100, 32'hB0,       1, 2'd2);
    vecs[16] = mk(0, 32'h0,   32'h0,        0, 1, 0, 32'h0,   32'h0,        1, 2'd0);
    vecs[17] = mk(1, 32'h200, 32'hB2,       0, 1, 0, 32'h0,   32'h0,        1, 2'd0);
    vecs[18] = mk(0, 32'h0,   32'h0,        0, 1, 1, 32'h200, 32'hB2,       1, 2'd1);
    vecs[19] = mk(0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 2'd0);

    rst            = 1'b0;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_instruction = '0;
    flush          = 1'b0;
    id_ready       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAll("reset", 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Assert reset asynchronously between clock edges while one word is queued.
    @(negedge clk);
    if_valid = 1'b1; if_pc = 32'h300; if_instruction = 32'hD0; id_ready = 1'b0;
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    checkAll("pre_async", 1'b1, 32'h300, 32'hD0, 1'b1, 2'd1);
    #1;
    rst = 1'b0;
    #1;
    checkAll("async_rst", 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAll("post_rst", 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
